// File: rtl/charmatrix_frame_gen_if.sv
// Pixel stream link between the frame generator (master) and the ws2812b driver (slave).
interface charmatrix_frame_gen_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_latch;
  logic        pix_ready;

  modport master (output pix_data, pix_valid, pix_latch, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_latch, output pix_ready);
endinterface

// File: rtl/charmatrix_frame_gen.sv
// Character-matrix frame engine: byte-fed text/colour buffer, periodic glyph/colour ROM walk,
// one GRB word per LED to the strip driver. Define CHARMATRIX_DIM_EN to add the dim[1:0] input.
module charmatrix_frame_gen #(
  parameter int          NUM_CHARS   = 4,
  parameter int          GLYPH_BITS  = 35,
  parameter int          CIDX_W      = 4,
  parameter int          REFRESH_DIV = 65536,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic                  clk20,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic [CIDX_W-1:0]     rx_color,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  mode_scroll,
  output logic [7:0]            char_index,
  input  logic [GLYPH_BITS-1:0] char_data,
  output logic [CIDX_W-1:0]     color_index,
  input  logic [23:0]           color_data,
`ifdef CHARMATRIX_DIM_EN
  input  logic [1:0]            dim,
`endif
  charmatrix_frame_gen_if.master pix,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TOTAL = NUM_CHARS * GLYPH_BITS;
  localparam int LED_W = $clog2(TOTAL + 1);
  localparam int CHR_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int BIT_W = (GLYPH_BITS > 1) ? $clog2(GLYPH_BITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_READY, WAIT_STARTED} state_t;

  state_t            state, state_next;
  logic [7:0]        text [NUM_CHARS];
  logic [CIDX_W-1:0] cols [NUM_CHARS];
  logic [CHR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  refresh_cnt;
  logic              refresh_tick;
  logic [LED_W-1:0]  led;
  logic [BIT_W-1:0]  bit_idx;
  logic [CHR_W-1:0]  chr;
  logic              accept;
  logic [23:0]       lit_color;

  assign accept = rx_valid && rx_ready;

`ifdef CHARMATRIX_DIM_EN
  assign lit_color = {color_data[23:16] >> dim, color_data[15:8] >> dim, color_data[7:0] >> dim};
`else
  assign lit_color = color_data;
`endif

  always_ff @(posedge clk20) begin
    if (reset) begin
      refresh_cnt  <= '0;
      refresh_tick <= 1'b0;
    end else begin
      refresh_tick <= (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
      refresh_cnt  <= (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) ? '0 : refresh_cnt + CNT_W'(1);
    end
  end

  // Control codes 0x0C/0x0D are consumed here and never reach the buffer.
  always_ff @(posedge clk20) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
        text[CHR_W'(i)] <= BLANK_CHAR;
        cols[CHR_W'(i)] <= '0;
      end
      wr_ptr   <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= !accept;
      if (accept) begin
        if (rx_data == 8'h0C) begin
          for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            text[CHR_W'(i)] <= BLANK_CHAR;
            cols[CHR_W'(i)] <= '0;
          end
          wr_ptr <= '0;
        end else if (rx_data == 8'h0D) begin
          wr_ptr <= '0;
        end else if (mode_scroll) begin
          for (int unsigned i = 0; i + 1 < NUM_CHARS; i++) begin
            text[CHR_W'(i)] <= text[CHR_W'(i + 1)];
            cols[CHR_W'(i)] <= cols[CHR_W'(i + 1)];
          end
          text[CHR_W'(NUM_CHARS - 1)] <= rx_data;
          cols[CHR_W'(NUM_CHARS - 1)] <= rx_color;
        end else begin
          text[wr_ptr] <= rx_data;
          cols[wr_ptr] <= rx_color;
          wr_ptr <= (wr_ptr == CHR_W'(NUM_CHARS - 1)) ? '0 : wr_ptr + CHR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk20) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (refresh_tick) state_next = FETCH;
      FETCH:        state_next = LOAD;
      LOAD:         state_next = WAIT_READY;
      WAIT_READY:   if (pix.pix_ready) state_next = WAIT_STARTED;
      WAIT_STARTED: begin
        if (!pix.pix_ready) begin
          if (led == LED_W'(TOTAL)) state_next = IDLE;
          else if (bit_idx == '0)   state_next = FETCH;
          else                      state_next = LOAD;
        end
      end
      default:      state_next = IDLE;
    endcase
  end

  // bit_idx wrapping to 0 after the advance marks the start of a new character.
  always_ff @(posedge clk20) begin
    if (reset) begin
      led           <= '0;
      bit_idx       <= '0;
      chr           <= '0;
      char_index    <= '0;
      color_index   <= '0;
      pix.pix_data  <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_latch <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (refresh_tick) begin
          led     <= '0;
          bit_idx <= '0;
          chr     <= '0;
          busy    <= 1'b1;
        end
        FETCH: begin
          char_index  <= text[chr];
          color_index <= cols[chr];
        end
        LOAD: begin
          pix.pix_data  <= char_data[bit_idx] ? lit_color : '0;
          pix.pix_latch <= (led == LED_W'(TOTAL - 1));
        end
        WAIT_READY: if (pix.pix_ready) begin
          pix.pix_valid <= 1'b1;
          if (bit_idx == BIT_W'(GLYPH_BITS - 1)) begin
            bit_idx <= '0;
            chr     <= chr + CHR_W'(1);
          end else begin
            bit_idx <= bit_idx + BIT_W'(1);
          end
          led <= led + LED_W'(1);
        end
        WAIT_STARTED: if (!pix.pix_ready) begin
          pix.pix_valid <= 1'b0;
          if (led == LED_W'(TOTAL)) begin
            frame_done    <= 1'b1;
            busy          <= 1'b0;
            pix.pix_latch <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
